// File: rtl/ro_scan_pkg.sv
// ro_scan_pkg: shared types and width helpers for the aging-sensor scan monitor.
//   state_t : scan sequencer FSM states
//   mode_t  : baseline / compare scan mode
//   width_of: index width for n items (minimum 1 bit)
//   alarm_w : width of a counter that must reach `entries`
package ro_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    MODE_BASELINE = 1'b0,
    MODE_COMPARE  = 1'b1
  } mode_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned alarm_w(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/ro_baseline_mem.sv
// ro_baseline_mem: reference-count store, one entry per (region, address).
//   clk               : write clock
//   we, wr_region,
//   wr_addr, wr_data  : synchronous write port
//   rd_region,
//   rd_addr, rd_data  : asynchronous read port (out-of-range index reads 0)
// Contents are deliberately not reset.
module ro_baseline_mem
  import ro_scan_pkg::*;
#(
  parameter int unsigned NUM_REGION = 17,
  parameter int unsigned NUM_ADDR   = 10,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 24
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [width_of(NUM_REGION)-1:0] wr_region,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [width_of(NUM_REGION)-1:0] rd_region,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [DATA_W-1:0]               rd_data
);

  localparam int unsigned DEPTH = NUM_REGION * NUM_ADDR;
  localparam int unsigned IDX_W = width_of(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       wr_idx;
  logic [31:0]       rd_idx;

  always_comb begin
    wr_idx = 32'(wr_region) * NUM_ADDR + 32'(wr_addr);
    rd_idx = 32'(rd_region) * NUM_ADDR + 32'(rd_addr);
  end

  always_ff @(posedge clk) begin
    if (we && (wr_idx < DEPTH)) begin
      mem[wr_idx[IDX_W-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx < DEPTH) begin
      rd_data = mem[rd_idx[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/ro_scan_monitor.sv
// ro_scan_monitor: walks every oscillator address across all regions and
// streams the captured counts over valid/ready. Baseline scans store a
// reference per (region, address); compare scans emit baseline - sample and
// flag entries whose degradation exceeds the threshold.
//   start_i/mode_i/threshold_i : scan request, sampled in IDLE
//   abort_i                    : return to IDLE next cycle, no done pulse
//   scan_addr_o                : address broadcast to all regions
//   region_data_i              : flattened per-region counts
//   out_*                      : registered stream beat
//   busy_o/done_o              : status; done_o is a one-cycle pulse
//   baseline_valid_o           : a baseline scan has completed
//   alarm_cnt_o                : flags raised in current/last scan
module ro_scan_monitor
  import ro_scan_pkg::*;
#(
  parameter int unsigned NUM_REGION = 17,
  parameter int unsigned NUM_ADDR   = 10,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SETTLE     = 2
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     start_i,
  input  logic                                     mode_i,
  input  logic                                     abort_i,
  input  logic [DATA_W-1:0]                        threshold_i,
  output logic [ADDR_W-1:0]                        scan_addr_o,
  input  logic [NUM_REGION*DATA_W-1:0]             region_data_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [width_of(NUM_REGION)-1:0]          out_region_o,
  output logic [ADDR_W-1:0]                        out_addr_o,
  output logic [DATA_W-1:0]                        out_data_o,
  output logic [DATA_W:0]                          out_delta_o,
  output logic                                     out_flag_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     baseline_valid_o,
  output logic [alarm_w(NUM_REGION*NUM_ADDR)-1:0]  alarm_cnt_o
);

  localparam int unsigned REG_W = width_of(NUM_REGION);
  localparam int unsigned SET_W = width_of(SETTLE);

  state_t              state;
  mode_t               mode;
  logic [DATA_W-1:0]   thr;
  logic [SET_W-1:0]    settle_cnt;
  logic [REG_W-1:0]    region;

  logic [REG_W-1:0]    rd_region;
  logic [DATA_W-1:0]   sample;
  logic [DATA_W-1:0]   base_rd;
  logic [DATA_W:0]     delta_next;
  logic                flag_next;
  logic                hs;
  logic                last_region;
  logic                last_addr;
  logic                mem_we;

  assign hs          = out_valid_o && out_ready_i;
  assign last_region = (region == REG_W'(NUM_REGION - 1));
  assign last_addr   = (scan_addr_o == ADDR_W'(NUM_ADDR - 1));
  assign busy_o      = (state != ST_IDLE);

  // The capture on the next clock edge is always for the region that will be
  // current afterwards: region 0 from SETTLE, region+1 on an EMIT handshake.
  always_comb begin
    rd_region = (state == ST_EMIT) ? region + REG_W'(1) : region;
  end

  always_comb begin
    sample = '0;
    if (32'(rd_region) < NUM_REGION) begin
      sample = region_data_i[32'(rd_region)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    delta_next = {1'b0, base_rd} - {1'b0, sample};
    flag_next  = $signed(delta_next) > $signed({1'b0, thr});
  end

  assign mem_we = (state == ST_EMIT) && hs && !abort_i && (mode == MODE_BASELINE);

  ro_baseline_mem #(
    .NUM_REGION (NUM_REGION),
    .NUM_ADDR   (NUM_ADDR),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) u_mem (
    .clk       (clk),
    .we        (mem_we),
    .wr_region (out_region_o),
    .wr_addr   (out_addr_o),
    .wr_data   (out_data_o),
    .rd_region (rd_region),
    .rd_addr   (scan_addr_o),
    .rd_data   (base_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      mode             <= MODE_BASELINE;
      thr              <= '0;
      settle_cnt       <= '0;
      region           <= '0;
      scan_addr_o      <= '0;
      out_valid_o      <= 1'b0;
      out_region_o     <= '0;
      out_addr_o       <= '0;
      out_data_o       <= '0;
      out_delta_o      <= '0;
      out_flag_o       <= 1'b0;
      done_o           <= 1'b0;
      baseline_valid_o <= 1'b0;
      alarm_cnt_o      <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state       <= ST_IDLE;
        out_valid_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              mode        <= (mode_i && baseline_valid_o) ? MODE_COMPARE : MODE_BASELINE;
              thr         <= threshold_i;
              scan_addr_o <= '0;
              region      <= '0;
              settle_cnt  <= '0;
              alarm_cnt_o <= '0;
              state       <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == SET_W'(SETTLE - 1)) begin
              state        <= ST_EMIT;
              out_valid_o  <= 1'b1;
              out_region_o <= rd_region;
              out_addr_o   <= scan_addr_o;
              out_data_o   <= sample;
              out_delta_o  <= (mode == MODE_COMPARE) ? delta_next : '0;
              out_flag_o   <= (mode == MODE_COMPARE) && flag_next;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          ST_EMIT: begin
            if (hs) begin
              if (out_flag_o && (alarm_cnt_o != '1)) begin
                alarm_cnt_o <= alarm_cnt_o + 1'b1;
              end
              if (!last_region) begin
                region       <= rd_region;
                out_region_o <= rd_region;
                out_addr_o   <= scan_addr_o;
                out_data_o   <= sample;
                out_delta_o  <= (mode == MODE_COMPARE) ? delta_next : '0;
                out_flag_o   <= (mode == MODE_COMPARE) && flag_next;
              end else begin
                out_valid_o <= 1'b0;
                region      <= '0;
                if (!last_addr) begin
                  scan_addr_o <= scan_addr_o + ADDR_W'(1);
                  settle_cnt  <= '0;
                  state       <= ST_SETTLE;
                end else begin
                  done_o <= 1'b1;
                  if (mode == MODE_BASELINE) begin
                    baseline_valid_o <= 1'b1;
                  end
                  state <= ST_DONE;
                end
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_scan_monitor.sv
// tb_ro_scan_monitor: directed bench for ro_scan_monitor with 4 regions,
// 2 addresses, SETTLE=2. Region counts are 1000 + 10*r + addr + off[r].
module tb_ro_scan_monitor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [23:0] threshold_i = '0;
  logic [4:0]  scan_addr_o;
  logic [95:0] region_data_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [1:0]  out_region_o;
  logic [4:0]  out_addr_o;
  logic [23:0] out_data_o;
  logic [24:0] out_delta_o;
  logic        out_flag_o;
  logic        busy_o;
  logic        done_o;
  logic        baseline_valid_o;
  logic [3:0]  alarm_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  int off [4];

  int          nb;
  int          done_cyc;
  bit          aborted;
  logic [1:0]  br   [16];
  logic [4:0]  ba   [16];
  logic [23:0] bdat [16];
  logic [24:0] bdel [16];
  logic        bfl  [16];

  ro_scan_monitor #(
    .NUM_REGION (4),
    .NUM_ADDR   (2),
    .ADDR_W     (5),
    .DATA_W     (24),
    .SETTLE     (2)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_i          (start_i),
    .mode_i           (mode_i),
    .abort_i          (abort_i),
    .threshold_i      (threshold_i),
    .scan_addr_o      (scan_addr_o),
    .region_data_i    (region_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_region_o     (out_region_o),
    .out_addr_o       (out_addr_o),
    .out_data_o       (out_data_o),
    .out_delta_o      (out_delta_o),
    .out_flag_o       (out_flag_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .baseline_valid_o (baseline_valid_o),
    .alarm_cnt_o      (alarm_cnt_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    region_data_i = '0;
    for (int r = 0; r < 4; r++) begin
      region_data_i[r*24 +: 24] = 24'(1000 + 10*r + int'(scan_addr_o) + off[r]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one scan; abort_at >= 0 aborts while that beat index is presented.
  task automatic run_scan(input logic m, input logic [23:0] thr, input bit rnd, input int abort_at);
    bit          held;
    logic [1:0]  h_reg;
    logic [4:0]  h_addr;
    logic [23:0] h_dat;
    logic [24:0] h_del;
    logic        h_fl;
    int          cyc;
    nb = 0; done_cyc = 0; aborted = 0; held = 0;
    h_reg = '0; h_addr = '0; h_dat = '0; h_del = '0; h_fl = 1'b0;
    @(negedge clk);
    mode_i = m; threshold_i = thr; start_i = 1'b1; out_ready_i = 1'b0;
    cyc = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start_i = 1'b0;
      mode_i = 1'b0;
      if (i == 0) check("busy_after_start", 64'(busy_o), 64'd1);
      if (aborted) begin
        abort_i = 1'b0;
        check("abort_valid_low", 64'(out_valid_o), 64'd0);
        check("abort_busy_low", 64'(busy_o), 64'd0);
        break;
      end
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      if (held) begin
        check("hold_valid", 64'(out_valid_o), 64'd1);
        check("hold_region", 64'(out_region_o), 64'(h_reg));
        check("hold_addr", 64'(out_addr_o), 64'(h_addr));
        check("hold_data", 64'(out_data_o), 64'(h_dat));
        check("hold_delta", 64'(out_delta_o), 64'(h_del));
        check("hold_flag", 64'(out_flag_o), 64'(h_fl));
      end
      if (out_valid_o && nb == abort_at) begin
        abort_i = 1'b1;
        out_ready_i = 1'b0;
        aborted = 1;
        held = 0;
        continue;
      end
      out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid_o && out_ready_i && nb < 16) begin
        check("scan_addr_bcast", 64'(scan_addr_o), 64'(nb / 4));
        br[nb] = out_region_o; ba[nb] = out_addr_o; bdat[nb] = out_data_o;
        bdel[nb] = out_delta_o; bfl[nb] = out_flag_o;
        nb++;
      end
      held   = out_valid_o && !out_ready_i;
      h_reg  = out_region_o; h_addr = out_addr_o; h_dat = out_data_o;
      h_del  = out_delta_o;  h_fl   = out_flag_o;
    end
    out_ready_i = 1'b0;
    if (!aborted) begin
      check("scan_done_seen", 64'(done_cyc != 0), 64'd1);
      if (done_cyc != 0) begin
        @(negedge clk);
        check("done_one_cycle", 64'(done_o), 64'd0);
        check("idle_after_done", 64'(busy_o), 64'd0);
      end
    end
  endtask

  // Expected beat k: region k%4, addr k/4; delta = baseline - sample = -off[r].
  task automatic verify_beats(input bit cmp, input int thr);
    logic [24:0] ed;
    check("beat_count", 64'(nb), 64'd8);
    for (int k = 0; k < nb && k < 8; k++) begin
      ed = cmp ? 25'(-off[k % 4]) : 25'd0;
      check("beat_region", 64'(br[k]), 64'(k % 4));
      check("beat_addr", 64'(ba[k]), 64'(k / 4));
      check("beat_data", 64'(bdat[k]), 64'(1000 + 10*(k % 4) + k/4 + off[k % 4]));
      check("beat_delta", 64'(bdel[k]), 64'(ed));
      check("beat_flag", 64'(bfl[k]), 64'(cmp && (-off[k % 4] > thr)));
    end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) off[r] = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_bvalid", 64'(baseline_valid_o), 64'd0);
    check("rst_addr", 64'(scan_addr_o), 64'd0);
    check("rst_alarm", 64'(alarm_cnt_o), 64'd0);
    check("rst_data", 64'(out_data_o), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Baseline scan with continuous ready
    run_scan(1'b0, 24'd0, 1'b0, -1);
    verify_beats(1'b0, 0);
    check("s1_done_cycle", 64'(done_cyc), 64'd14);
    check("s1_bvalid", 64'(baseline_valid_o), 64'd1);
    check("s1_alarm", 64'(alarm_cnt_o), 64'd0);

    // Compare: every sample 5 below baseline, threshold 3
    for (int r = 0; r < 4; r++) off[r] = -5;
    run_scan(1'b1, 24'd3, 1'b0, -1);
    verify_beats(1'b1, 3);
    check("s2_done_cycle", 64'(done_cyc), 64'd14);
    check("s2_alarm", 64'(alarm_cnt_o), 64'd8);

    // Mixed compare: region 2 is 20 above baseline, threshold 0
    off[2] = 20;
    run_scan(1'b1, 24'd0, 1'b0, -1);
    verify_beats(1'b1, 0);
    check("s3_delta_r2", 64'(bdel[2]), 64'h1FFFFEC);
    check("s3_alarm", 64'(alarm_cnt_o), 64'd6);

    // Baseline under random backpressure
    for (int r = 0; r < 4; r++) off[r] = 0;
    run_scan(1'b0, 24'd0, 1'b1, -1);
    verify_beats(1'b0, 0);
    check("s4_bvalid", 64'(baseline_valid_o), 64'd1);

    // Abort while the third beat is presented
    run_scan(1'b0, 24'd0, 1'b0, 2);
    check("abort_taken", 64'(aborted), 64'd1);
    check("abort_beats", 64'(nb), 64'd2);
    done_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_o) done_cyc = 1;
    end
    check("abort_no_done", 64'(done_cyc), 64'd0);
    check("abort_bvalid_kept", 64'(baseline_valid_o), 64'd1);
    check("abort_idle", 64'(busy_o), 64'd0);

    // Reset mid-scan
    @(negedge clk);
    start_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    rstn = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid_o), 64'd0);
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_bvalid", 64'(baseline_valid_o), 64'd0);
    check("mrst_addr", 64'(scan_addr_o), 64'd0);
    check("mrst_data", 64'(out_data_o), 64'd0);
    check("mrst_region", 64'(out_region_o), 64'd0);
    check("mrst_alarm", 64'(alarm_cnt_o), 64'd0);
    out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Compare request with no baseline runs as a baseline scan
    for (int r = 0; r < 4; r++) off[r] = -5;
    run_scan(1'b1, 24'd0, 1'b0, -1);
    verify_beats(1'b0, 0);
    check("s5_done_cycle", 64'(done_cyc), 64'd14);
    check("s5_bvalid", 64'(baseline_valid_o), 64'd1);
    check("s5_alarm", 64'(alarm_cnt_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
